// File: rtl/cmos_capture_rgb565.sv
// OV5640 DVP capture: pairs bytes into RGB565 words, crops to the frame-buffer
// window and only writes whole frames once SDRAM is ready and the sensor settled.
module cmos_capture_rgb565 #(
  parameter int H_ACTIVE    = 480,
  parameter int V_ACTIVE    = 272,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  input  logic        sdram_init_done,
  output logic        sys_we,
  output logic [15:0] sys_data_in,
  output logic        frame_valid,
  output logic [7:0]  frame_cnt,
  output logic        line_err
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] X_MAX  = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_MAX  = YW'(V_ACTIVE);
  localparam logic [7:0]    SKIP_N = 8'(SKIP_FRAMES);

  typedef enum logic [1:0] {WAIT_INIT, SKIP, ARMED, CAPTURE} state_t;

  logic          vsync_d_reg, vsync_dd_reg;
  logic          href_d_reg, href_dd_reg;
  logic [7:0]    data_d_reg;
  logic [1:0]    init_sync_reg;
  state_t        state_reg;
  logic [7:0]    skip_cnt_reg;
  logic [7:0]    frame_cnt_reg;
  logic          frame_valid_reg;
  logic [XW-1:0] x_cnt_reg;
  logic [YW-1:0] y_cnt_reg;
  logic          toggle_reg;
  logic [7:0]    hi_byte_reg;
  logic          word_we_reg;
  logic [15:0]   word_reg;
  logic          line_err_reg;
  logic          sys_we_reg;
  logic [15:0]   sys_data_reg;

  logic fs, fe, href_fall, in_window, capturing;

  assign fs        = vsync_dd_reg & ~vsync_d_reg;
  assign fe        = ~vsync_dd_reg & vsync_d_reg;
  assign href_fall = href_dd_reg & ~href_d_reg;
  assign in_window = (x_cnt_reg < X_MAX) && (y_cnt_reg < Y_MAX);
  assign capturing = (state_reg == CAPTURE);

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d_reg   <= 1'b0;
      vsync_dd_reg  <= 1'b0;
      href_d_reg    <= 1'b0;
      href_dd_reg   <= 1'b0;
      data_d_reg    <= 8'd0;
      init_sync_reg <= 2'b00;
    end else begin
      vsync_d_reg   <= cmos_vsync;
      vsync_dd_reg  <= vsync_d_reg;
      href_d_reg    <= cmos_href;
      href_dd_reg   <= href_d_reg;
      data_d_reg    <= cmos_data;
      init_sync_reg <= {init_sync_reg[0], sdram_init_done};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= WAIT_INIT;
      skip_cnt_reg    <= 8'd0;
      frame_cnt_reg   <= 8'd0;
      frame_valid_reg <= 1'b0;
    end else begin
      frame_valid_reg <= capturing;
      case (state_reg)
        WAIT_INIT: if (init_sync_reg[1]) begin
          state_reg    <= SKIP;
          skip_cnt_reg <= 8'd0;
        end
        SKIP: begin
          if (skip_cnt_reg == SKIP_N) state_reg <= ARMED;
          else if (fe)                skip_cnt_reg <= skip_cnt_reg + 8'd1;
        end
        // Waiting for a falling vsync guarantees we never join a frame midway.
        ARMED: if (fs) state_reg <= CAPTURE;
        CAPTURE: if (fe) begin
          state_reg     <= ARMED;
          frame_cnt_reg <= frame_cnt_reg + 8'd1;
        end
        default: state_reg <= WAIT_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_reg   <= 1'b0;
      hi_byte_reg  <= 8'd0;
      x_cnt_reg    <= '0;
      y_cnt_reg    <= '0;
      word_we_reg  <= 1'b0;
      word_reg     <= 16'd0;
      line_err_reg <= 1'b0;
    end else begin
      word_we_reg <= 1'b0;
      if (!capturing) begin
        toggle_reg <= 1'b0;
        x_cnt_reg  <= '0;
        y_cnt_reg  <= '0;
      end else begin
        if (href_d_reg) begin
          toggle_reg <= ~toggle_reg;
          if (!toggle_reg) begin
            hi_byte_reg <= data_d_reg;
          end else if (!fe) begin
            // A word completing on the frame-end cycle is dropped so no write
            // can land after frame_valid falls.
            if (in_window) begin
              word_we_reg <= 1'b1;
              word_reg    <= {hi_byte_reg, data_d_reg};
            end
            if (x_cnt_reg != X_MAX) x_cnt_reg <= x_cnt_reg + 1'b1;
          end
        end else begin
          toggle_reg <= 1'b0;
        end
        if (href_fall) begin
          x_cnt_reg <= '0;
          if (y_cnt_reg != Y_MAX) y_cnt_reg <= y_cnt_reg + 1'b1;
          if (in_window) line_err_reg <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sys_we_reg   <= 1'b0;
      sys_data_reg <= 16'd0;
    end else begin
      sys_we_reg <= word_we_reg;
      if (word_we_reg) sys_data_reg <= word_reg;
    end
  end

  assign sys_we      = sys_we_reg;
  assign sys_data_in = sys_data_reg;
  assign frame_valid = frame_valid_reg;
  assign frame_cnt   = frame_cnt_reg;
  assign line_err    = line_err_reg;

endmodule

// File: tb/tb_cmos_capture_rgb565.sv
// Drives a small synthetic DVP sensor into two capture instances (skip 2 / skip 0)
// and compares every written word, its timing and the status outputs to a frame model.
module tb_cmos_capture_rgb565;

  localparam int H = 8;
  localparam int V = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cmos_vsync, cmos_href;
  logic [7:0]  cmos_data;
  logic        init_m, init_z;
  logic        we_m, fv_m, lerr_m, we_z, fv_z, lerr_z;
  logic [15:0] data_m, data_z;
  logic [7:0]  fc_m, fc_z;

  cmos_capture_rgb565 #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .sdram_init_done(init_m), .sys_we(we_m),
    .sys_data_in(data_m), .frame_valid(fv_m), .frame_cnt(fc_m), .line_err(lerr_m));

  cmos_capture_rgb565 #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(0)) dut_z (
    .clk(clk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .sdram_init_done(init_z), .sys_we(we_z),
    .sys_data_in(data_z), .frame_valid(fv_z), .frame_cnt(fc_z), .line_err(lerr_z));

  typedef struct packed { logic [15:0] w; logic [31:0] c; } wrec_t;

  typedef struct {
    int pairs; int lines; bit odd;
    int short_line; int short_pairs;
    int fe_line; int fe_byte; bit preset;
    bit cap_m; bit cap_z;
    int exp_words_m; bit exp_lerr;
  } frame_t;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wrec_t got_m[$], got_z[$], exp_m[$], exp_z[$];
  int unsigned rise_m = 0, fall_m = 0, vs_low_cyc = 0, vs_high_cyc = 0;
  int viol = 0;
  logic fvp_m = 1'b0;
  int n_checks = 0, n_pass = 0;
  logic [7:0] exp_fc_m = 8'd0, exp_fc_z = 8'd0;

  function automatic wrec_t mk_rec(input logic [15:0] w, input int unsigned c);
    wrec_t r;
    r.w = w;
    r.c = c;
    return r;
  endfunction

  always @(negedge clk) begin
    if (we_m) got_m.push_back(mk_rec(data_m, cyc));
    if (we_z) got_z.push_back(mk_rec(data_z, cyc));
    if (we_m && !fv_m) viol++;
    if (we_z && !fv_z) viol++;
    if (fv_m && !fvp_m) rise_m = cyc;
    if (!fv_m && fvp_m) fall_m = cyc;
    fvp_m = fv_m;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic frame_t mk(int pairs, int lines, bit odd, int sl, int sp, int fl, int fb,
                                bit pre, bit cm, bit cz, int ew, bit el);
    frame_t f;
    f.pairs = pairs; f.lines = lines; f.odd = odd;
    f.short_line = sl; f.short_pairs = sp;
    f.fe_line = fl; f.fe_byte = fb; f.preset = pre;
    f.cap_m = cm; f.cap_z = cz;
    f.exp_words_m = ew; f.exp_lerr = el;
    return f;
  endfunction

  function automatic logic [7:0] preset_byte(input int i);
    case (i)
      0: return 8'hF8;
      1: return 8'h00;
      2: return 8'h07;
      default: return 8'hE0;
    endcase
  endfunction

  task automatic clear_obs();
    got_m.delete(); got_z.delete(); exp_m.delete(); exp_z.delete();
    rise_m = 0; fall_m = 0; viol = 0;
  endtask

  // Sensor model; also records the words each captured frame must produce and
  // the cycle at which each must appear (low byte drive + 3 negedges).
  task automatic send_frame(input frame_t f);
    int np, nb;
    logic [7:0] b, hi;
    bit ended;
    hi = 8'd0; ended = 1'b0;
    cmos_vsync = 1'b1; cmos_href = 1'b0;
    repeat (6) @(negedge clk);
    cmos_vsync = 1'b0; vs_low_cyc = cyc;
    for (int l = 0; l < f.lines; l++) begin
      if (!ended) begin
        repeat (3) @(negedge clk);
        np = (l == f.short_line) ? f.short_pairs : f.pairs;
        nb = 2 * np + (f.odd ? 1 : 0);
        for (int i = 0; i < nb; i++) begin
          @(negedge clk);
          b = 8'($urandom);
          if (f.preset && l == 0 && i < 4) b = preset_byte(i);
          cmos_href = 1'b1; cmos_data = b;
          if (l == f.fe_line && i == f.fe_byte) begin
            cmos_vsync = 1'b1; vs_high_cyc = cyc; ended = 1'b1;
          end
          if (i % 2 == 0) hi = b;
          else if (!ended && l < V && i / 2 < H) begin
            if (f.cap_m) exp_m.push_back(mk_rec({hi, b}, cyc + 3));
            if (f.cap_z) exp_z.push_back(mk_rec({hi, b}, cyc + 3));
          end
        end
        @(negedge clk);
        cmos_href = 1'b0;
      end
    end
    if (!ended) begin
      repeat (2) @(negedge clk);
      cmos_vsync = 1'b1; vs_high_cyc = cyc;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input int idx, input frame_t f);
    int n;
    if (f.cap_m) exp_fc_m++;
    if (f.cap_z) exp_fc_z++;
    chk($sformatf("f%0d word_count_m", idx), got_m.size(), f.exp_words_m);
    chk($sformatf("f%0d word_count_z", idx), got_z.size(), exp_z.size());
    n = (got_m.size() < exp_m.size()) ? got_m.size() : exp_m.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("f%0d word_m[%0d] {data,cycle}", idx, i), got_m[i], exp_m[i]);
    n = (got_z.size() < exp_z.size()) ? got_z.size() : exp_z.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("f%0d word_z[%0d] {data,cycle}", idx, i), got_z[i], exp_z[i]);
    if (f.preset) begin
      if (got_m.size() >= 2) begin
        chk($sformatf("f%0d first_word", idx), got_m[0].w, 16'hF800);
        chk($sformatf("f%0d second_word", idx), got_m[1].w, 16'h07E0);
      end else begin
        chk($sformatf("f%0d preset_words_present", idx), got_m.size(), 2);
      end
    end
    chk($sformatf("f%0d frame_cnt_m", idx), fc_m, exp_fc_m);
    chk($sformatf("f%0d frame_cnt_z", idx), fc_z, exp_fc_z);
    chk($sformatf("f%0d line_err_m", idx), lerr_m, f.exp_lerr);
    chk($sformatf("f%0d line_err_z", idx), lerr_z, f.exp_lerr);
    chk($sformatf("f%0d we_outside_frame_valid", idx), viol, 0);
    if (f.cap_m) begin
      chk($sformatf("f%0d fv_rise_cycle", idx), rise_m, vs_low_cyc + 3);
      chk($sformatf("f%0d fv_fall_cycle", idx), fall_m, vs_high_cyc + 3);
    end else begin
      chk($sformatf("f%0d fv_stays_low", idx), rise_m, 0);
    end
    $display("frame %0d: m words=%0d fc=%0d lerr=%0d | z words=%0d fc=%0d lerr=%0d",
             idx, got_m.size(), fc_m, lerr_m, got_z.size(), fc_z, lerr_z);
  endtask

  initial begin
    frame_t tbl[16];
    int k;
    tbl[0]  = mk(8, 4, 0, -1, 0, -1, 0, 0, 0, 1, 0, 0);
    tbl[1]  = mk(10, 6, 1, -1, 0, -1, 0, 0, 0, 1, 0, 0);
    tbl[2]  = mk(8, 4, 0, -1, 0, -1, 0, 1, 1, 1, 32, 0);
    tbl[3]  = mk(10, 6, 1, -1, 0, -1, 0, 0, 1, 1, 32, 0);
    tbl[4]  = mk(8, 4, 1, -1, 0, -1, 0, 0, 1, 1, 32, 0);
    tbl[5]  = mk(8, 2, 0, -1, 0, -1, 0, 0, 1, 1, 16, 0);
    tbl[6]  = mk(8, 6, 0, 5, 2, -1, 0, 0, 1, 1, 32, 0);
    tbl[7]  = mk(8, 4, 0, -1, 0, 1, 7, 0, 1, 1, 11, 0);
    tbl[8]  = mk(8, 4, 0, 1, 3, -1, 0, 0, 1, 1, 27, 1);
    tbl[9]  = mk(9, 5, 0, -1, 0, -1, 0, 0, 1, 1, 32, 1);
    tbl[10] = mk(8, 4, 0, -1, 0, -1, 0, 0, 1, 1, 0, 0);
    tbl[11] = mk(8, 4, 0, -1, 0, -1, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(8, 4, 0, -1, 0, -1, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(8, 4, 0, -1, 0, -1, 0, 0, 0, 1, 0, 0);
    tbl[14] = mk(8, 4, 0, -1, 0, -1, 0, 0, 0, 1, 0, 0);
    tbl[15] = mk(8, 4, 0, -1, 0, -1, 0, 0, 1, 1, 32, 0);

    rst = 1'b1; cmos_vsync = 1'b1; cmos_href = 1'b0; cmos_data = 8'd0;
    init_m = 1'b0; init_z = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset sys_we", we_m, 0);
    chk("reset sys_data_in", data_m, 0);
    chk("reset frame_valid", fv_m, 0);
    chk("reset frame_cnt", fc_m, 0);
    chk("reset line_err", lerr_m, 0);
    chk("reset frame_valid_z", fv_z, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle sys_we", we_m, 0);
    chk("idle frame_valid", fv_m, 0);

    init_m = 1'b1; init_z = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      clear_obs();
      send_frame(tbl[i]);
      check_frame(i, tbl[i]);
    end

    // Reset in the middle of a captured frame.
    clear_obs();
    fork
      send_frame(tbl[10]);
      begin
        k = 0;
        while (got_m.size() < 10 && k < 1000) begin
          @(negedge clk);
          k++;
        end
        chk("reached word 10 before reset", (k < 1000) ? 1 : 0, 1);
        rst = 1'b1; init_m = 1'b0; init_z = 1'b0;
        @(negedge clk);
        chk("midframe rst sys_we", we_m, 0);
        chk("midframe rst frame_valid", fv_m, 0);
        chk("midframe rst frame_cnt", fc_m, 0);
        chk("midframe rst line_err", lerr_m, 0);
        chk("midframe rst sys_data_in", data_m, 0);
        chk("midframe rst frame_valid_z", fv_z, 0);
        rst = 1'b0;
      end
    join
    exp_fc_m = 8'd0; exp_fc_z = 8'd0;

    clear_obs();
    send_frame(tbl[11]);
    check_frame(11, tbl[11]);

    // SDRAM init arrives mid-frame on the zero-skip instance.
    clear_obs();
    fork
      send_frame(tbl[12]);
      begin
        repeat (30) @(negedge clk);
        init_z = 1'b1;
      end
    join
    check_frame(12, tbl[12]);

    init_m = 1'b1;
    for (int i = 13; i < 16; i++) begin
      clear_obs();
      send_frame(tbl[i]);
      check_frame(i, tbl[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
